// File: rtl/me_pkg.sv
// me_pkg: shared motion-estimation widths, saturation limit and candidate result type
package me_pkg;
  localparam int PART_W = 16;
  localparam int SAD_W = 22;
  localparam int CAND_W = 10;
  localparam logic [SAD_W-1:0] SAD_MAX = '1;
  typedef struct packed {
    logic [SAD_W-1:0]  sad;
    logic [CAND_W-1:0] idx;
    logic              last;
  } cand_res_t;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sad_min_tracker_if.sv
// sad_min_tracker_if: partial-SAD input stream and min-SAD result bundle
interface sad_min_tracker_if;
  import me_pkg::*;
  logic              part_valid;
  logic [PART_W-1:0] part_sad;
  logic [CAND_W-1:0] cand_idx;
  logic              last_cand;
  logic              clear;
  logic [SAD_W-1:0]  min_sad;
  logic [CAND_W-1:0] min_idx;
  logic              finish_a_cur;
  logic              busy;
  logic              sat_flag;
  modport master (output part_valid, part_sad, cand_idx, last_cand, clear,
                  input min_sad, min_idx, finish_a_cur, busy, sat_flag);
  modport slave (input part_valid, part_sad, cand_idx, last_cand, clear,
                 output min_sad, min_idx, finish_a_cur, busy, sat_flag);
endinterface

// File: rtl/sad_row_accum.sv
// sad_row_accum: row counter and saturating accumulator producing one total per candidate
module sad_row_accum import me_pkg::*; #(
  parameter int ROWS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              part_valid,
  input  logic [PART_W-1:0] part_sad,
  input  logic [CAND_W-1:0] cand_idx,
  input  logic              last_cand,
  output logic              busy_row,
  output logic              blk_start,
  output logic              sat_evt,
  output logic              done,
  output cand_res_t         res
);
  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  logic [RW-1:0] row_q, row_d;
  logic [SAD_W-1:0] acc_q, acc_d, added;
  logic [SAD_W:0] sum;
  logic [CAND_W-1:0] idx_q, idx_d;
  logic last_q, last_d, blk_q, blk_d, done_q, done_d, acc_v, row0;
  cand_res_t res_q, res_d;
  // blk_q remembers whether the next row 0 opens a new block
  always_comb begin
    acc_v = part_valid & ~clear;
    row0 = row_q == '0;
    sum = {1'b0, acc_q} + (SAD_W+1)'(part_sad);
    added = sum[SAD_W] ? SAD_MAX : sum[SAD_W-1:0];
    sat_evt = acc_v & ~row0 & sum[SAD_W];
    blk_start = acc_v & row0 & blk_q;
    done_d = acc_v & (row_q == LAST_ROW);
    row_d = clear ? '0 : acc_v ? (done_d ? '0 : row_q + 1'b1) : row_q;
    acc_d = clear ? '0 : acc_v ? (row0 ? SAD_W'(part_sad) : added) : acc_q;
    idx_d = clear ? '0 : (acc_v & row0) ? cand_idx : idx_q;
    last_d = clear ? 1'b0 : (acc_v & row0) ? last_cand : last_q;
    blk_d = clear ? 1'b1 : (acc_v & row0) ? last_cand : blk_q;
    res_d = done_d ? cand_res_t'{sad: added, idx: idx_q, last: last_q} : res_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      last_q <= 1'b0;
      blk_q <= 1'b1;
      done_q <= 1'b0;
      res_q <= '0;
    end else begin
      row_q <= row_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      last_q <= last_d;
      blk_q <= blk_d;
      done_q <= done_d;
      res_q <= res_d;
    end
  end
  assign busy_row = ~row0;
  assign done = done_q;
  assign res = res_q;
endmodule

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: per-lane minimum total-SAD search over the candidates of one block
module sad_min_tracker import me_pkg::*; #(
  parameter int ROWS = 16
) (
  input logic clk,
  input logic rst,
  sad_min_tracker_if.slave bus
);
  logic busy_row, blk_start, sat_evt, done, take;
  logic cmp_v_q, cmp_v_d, seen_q, seen_d, fin_q, fin_d, sat_q, sat_d;
  logic [SAD_W-1:0] min_sad_q, min_sad_d;
  logic [CAND_W-1:0] min_idx_q, min_idx_d;
  cand_res_t res, cmp_q, cmp_d, best_q, best_d;
  state_t state_q, state_d;
  sad_row_accum #(.ROWS(ROWS)) u_accum (
    .clk(clk), .rst(rst), .clear(bus.clear), .part_valid(bus.part_valid),
    .part_sad(bus.part_sad), .cand_idx(bus.cand_idx), .last_cand(bus.last_cand),
    .busy_row(busy_row), .blk_start(blk_start), .sat_evt(sat_evt), .done(done), .res(res)
  );
  // seen_q clear means the candidate in compare is the first of its block
  always_comb begin
    cmp_v_d = ~bus.clear & done;
    cmp_d = bus.clear ? '0 : done ? res : cmp_q;
    take = ~seen_q | (cmp_q.sad < best_q.sad);
    best_d = (cmp_v_q & take) ? cmp_q : best_q;
    seen_d = bus.clear ? 1'b0 : cmp_v_q ? ~cmp_q.last : seen_q;
    fin_d = ~bus.clear & cmp_v_q & cmp_q.last;
    min_sad_d = fin_d ? best_d.sad : min_sad_q;
    min_idx_d = fin_d ? best_d.idx : min_idx_q;
    sat_d = blk_start ? 1'b0 : sat_q | sat_evt;
    state_d = bus.clear ? IDLE
            : (state_q == IDLE) ? (bus.part_valid ? RUN : IDLE)
            : (fin_d & ~busy_row & ~bus.part_valid) ? IDLE : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_v_q <= 1'b0;
      cmp_q <= '0;
      best_q <= '0;
      seen_q <= 1'b0;
      fin_q <= 1'b0;
      min_sad_q <= '0;
      min_idx_q <= '0;
      sat_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      cmp_v_q <= cmp_v_d;
      cmp_q <= cmp_d;
      best_q <= best_d;
      seen_q <= seen_d;
      fin_q <= fin_d;
      min_sad_q <= min_sad_d;
      min_idx_q <= min_idx_d;
      sat_q <= sat_d;
      state_q <= state_d;
    end
  end
  assign bus.min_sad = min_sad_q;
  assign bus.min_idx = min_idx_q;
  assign bus.finish_a_cur = fin_q;
  assign bus.busy = (state_q == RUN) | cmp_v_q;
  assign bus.sat_flag = sat_q;
endmodule
